// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory pipeline stage.
// Opcode constants, FSM state type and opcode classifier.
package mem_stage_ctrl_pkg;

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [31:0] ir);
        return (ir[31:27] == OP_LW) || (ir[31:27] == OP_SW);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_mw_reg.sv
// One 32-bit field of the M/W pipeline register.
// Loads on enable, clears asynchronously.
module mw_reg (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: passes ALU results through, runs LW/SW handshakes
// with a timeout, and presents results on the M/W register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              xm_valid,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    input  logic [31:0]       ir_in,
    output logic              xm_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mw_valid,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic [31:0]       mw_ir,
    input  logic              mw_ready,
    output logic              mem_err
);

    state_t      state_q;
    state_t      state_d;
    logic        kill_q;
    logic        resp_done_q;
    logic        lw_q;
    logic [7:0]  cnt_q;
    logic [31:0] o_q;
    logic [31:0] ir_q;
    logic [31:0] resp_data_q;

    logic        in_access;
    logic        can_out;
    logic        accept;
    logic        in_mem;
    logic        ev_ack;
    logic        ev_to;
    logic        done;
    logic        kill_eff;
    logic        complete;
    logic        hold_resp;
    logic        load_alu;
    logic        load_mem;
    logic        mw_load;
    logic [31:0] ev_data;
    logic [31:0] mw_o_d;
    logic [31:0] mw_d_d;
    logic [31:0] mw_ir_d;

    always_comb begin
        in_access = (state_q == ACCESS);
        can_out   = !mw_valid || mw_ready;
        xm_ready  = !in_access && can_out && !flush;
        accept    = xm_valid && xm_ready;
        in_mem    = is_mem_op(ir_in);
        ev_ack    = in_access && !resp_done_q && mem_ack;
        ev_to     = in_access && !resp_done_q && !mem_ack
                    && (cnt_q == 8'(TIMEOUT - 1));
        done      = resp_done_q || ev_ack || ev_to;
        kill_eff  = kill_q || flush;
        // a killed access never writes the output, so it need not wait
        complete  = in_access && done && (kill_eff || can_out);
        hold_resp = (ev_ack || ev_to) && !complete;
        ev_data   = (lw_q && ev_ack) ? mem_rdata : '0;
        load_alu  = accept && !in_mem;
        load_mem  = complete && !kill_eff;
        mw_load   = load_alu || load_mem;
        mw_o_d    = load_alu ? o_in : o_q;
        mw_ir_d   = load_alu ? ir_in : ir_q;
        mw_d_d    = '0;
        if (!load_alu) begin
            mw_d_d = resp_done_q ? resp_data_q : ev_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept && in_mem) state_d = ACCESS;
            ACCESS: if (complete) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            mw_valid    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_err     <= 1'b0;
            kill_q      <= 1'b0;
            resp_done_q <= 1'b0;
            resp_data_q <= '0;
            lw_q        <= 1'b0;
            cnt_q       <= '0;
            o_q         <= '0;
            ir_q        <= '0;
        end else begin
            mem_err <= mem_err | ev_to;
            if (mw_load) begin
                mw_valid <= 1'b1;
            end else if (!in_access && flush) begin
                mw_valid <= 1'b0;
            end else if (mw_ready) begin
                mw_valid <= 1'b0;
            end
            if (accept && in_mem) begin
                o_q         <= o_in;
                ir_q        <= ir_in;
                lw_q        <= (ir_in[31:27] == OP_LW);
                mem_addr    <= o_in[ADDR_W-1:0];
                mem_we      <= (ir_in[31:27] == OP_SW);
                mem_wdata   <= b_in;
                mem_req     <= 1'b1;
                cnt_q       <= '0;
                kill_q      <= 1'b0;
                resp_done_q <= 1'b0;
            end else if (in_access) begin
                if (flush) kill_q <= 1'b1;
                if (!done) cnt_q <= cnt_q + 8'd1;
                // response captured while the output is still blocked
                if (hold_resp) begin
                    resp_done_q <= 1'b1;
                    resp_data_q <= ev_data;
                    mem_req     <= 1'b0;
                end
                if (complete) begin
                    mem_req     <= 1'b0;
                    kill_q      <= 1'b0;
                    resp_done_q <= 1'b0;
                end
            end
        end
    end

    mw_reg u_mw_o (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (mw_load),
        .d       (mw_o_d),
        .q       (mw_o)
    );

    mw_reg u_mw_d (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (mw_load),
        .d       (mw_d_d),
        .q       (mw_d)
    );

    mw_reg u_mw_ir (
        .clk     (clk),
        .clear_n (clear_n),
        .en      (mw_load),
        .d       (mw_ir_d),
        .q       (mw_ir)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random traffic
// against an in-order transaction scoreboard.
module tb_mem_stage_ctrl;

    localparam int AW = 12;
    localparam int TO = 64;
    localparam logic [4:0] LW = 5'b01000;
    localparam logic [4:0] SW = 5'b00111;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          xm_valid;
    logic [31:0]   o_in;
    logic [31:0]   b_in;
    logic [31:0]   ir_in;
    logic          xm_ready;
    logic          flush;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic          mw_valid;
    logic [31:0]   mw_o;
    logic [31:0]   mw_d;
    logic [31:0]   mw_ir;
    logic          mw_ready;
    logic          mem_err;

    typedef struct {
        logic [31:0] o;
        logic [31:0] d;
        logic [31:0] ir;
    } res_t;

    typedef struct {
        logic [31:0] o;
        logic [31:0] b;
        logic [31:0] ir;
        int          dly;
    } req_t;

    res_t exp_q[$];
    req_t pend_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .xm_valid  (xm_valid),
        .o_in      (o_in),
        .b_in      (b_in),
        .ir_in     (ir_in),
        .xm_ready  (xm_ready),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mw_valid  (mw_valid),
        .mw_o      (mw_o),
        .mw_d      (mw_d),
        .mw_ir     (mw_ir),
        .mw_ready  (mw_ready),
        .mem_err   (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        xm_valid  = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mw_ready  = 1'b1;
        o_in      = '0;
        b_in      = '0;
        ir_in     = '0;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rnd_cycle(input bit allow_in);
        res_t        r;
        req_t        q;
        logic [4:0]  op;
        int          k;
        @(negedge clk);
        mem_ack  = 1'b0;
        mw_ready = ($urandom_range(0, 3) != 0);
        if (mw_valid) begin
            if (exp_q.size() == 0) begin
                check("rnd_spurious_valid", 32'(mw_valid), 32'd0);
            end else begin
                check("rnd_mw_o", mw_o, exp_q[0].o);
                check("rnd_mw_d", mw_d, exp_q[0].d);
                check("rnd_mw_ir", mw_ir, exp_q[0].ir);
                if (mw_ready) void'(exp_q.pop_front());
            end
        end
        if (mem_req) begin
            if (pend_q.size() == 0) begin
                check("rnd_spurious_req", 32'(mem_req), 32'd0);
            end else begin
                q = pend_q[0];
                check("rnd_addr", 32'(mem_addr), 32'(q.o[AW-1:0]));
                check("rnd_we", 32'(mem_we), 32'(q.ir[31:27] == SW));
                check("rnd_wdata", mem_wdata, q.b);
                if (q.dly == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                    r.o  = q.o;
                    r.ir = q.ir;
                    r.d  = (q.ir[31:27] == LW) ? mem_rdata : 32'd0;
                    exp_q.push_back(r);
                    void'(pend_q.pop_front());
                end else begin
                    q.dly--;
                    pend_q[0] = q;
                end
            end
        end
        xm_valid = allow_in && ($urandom_range(0, 1) == 1);
        k = $urandom_range(0, 3);
        op = 5'($urandom_range(0, 31));
        if (op == LW || op == SW) op = 5'b00000;
        if (k == 0) op = LW;
        if (k == 1) op = SW;
        ir_in = {op, 27'($urandom)};
        o_in  = $urandom;
        b_in  = $urandom;
        #1;
        if (mw_valid && !mw_ready) check("rnd_stall", 32'(xm_ready), 32'd0);
        if (xm_valid && xm_ready) begin
            if (op == LW || op == SW) begin
                q.o   = o_in;
                q.b   = b_in;
                q.ir  = ir_in;
                q.dly = $urandom_range(0, 5);
                pend_q.push_back(q);
            end else begin
                r.o  = o_in;
                r.d  = 32'd0;
                r.ir = ir_in;
                exp_q.push_back(r);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int low;
        int n;
        do_reset();
        check("rst_mw_valid", 32'(mw_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_mw_o", mw_o, 32'd0);
        check("rst_xm_ready", 32'(xm_ready), 32'd1);

        // ALU pass-through
        ir_in = 32'h0; o_in = 32'h5; xm_valid = 1'b1;
        @(negedge clk);
        xm_valid = 1'b0;
        check("add_valid", 32'(mw_valid), 32'd1);
        check("add_o", mw_o, 32'h5);
        check("add_d", mw_d, 32'h0);
        @(negedge clk);
        check("add_consumed", 32'(mw_valid), 32'd0);

        // load, ack on fourth request cycle
        ir_in = {LW, 27'h123}; o_in = 32'h10; xm_valid = 1'b1;
        low = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            xm_valid = 1'b0;
            if (!xm_ready) low++;
            if (i == 0) begin
                check("lw_req", 32'(mem_req), 32'd1);
                check("lw_addr", 32'(mem_addr), 32'h010);
                check("lw_we", 32'(mem_we), 32'd0);
            end
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        check("lw_stall_cycles", 32'(low), 32'd4);
        check("lw_valid", 32'(mw_valid), 32'd1);
        check("lw_d", mw_d, 32'hDEADBEEF);
        check("lw_o", mw_o, 32'h10);
        check("lw_req_drop", 32'(mem_req), 32'd0);

        // store, ack on first request cycle
        ir_in = {SW, 27'h0}; o_in = 32'h20; b_in = 32'h1234;
        xm_valid = 1'b1;
        @(negedge clk);
        xm_valid = 1'b0;
        check("sw_req", 32'(mem_req), 32'd1);
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_wdata", mem_wdata, 32'h1234);
        check("sw_not_yet", 32'(mw_valid), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("sw_valid", 32'(mw_valid), 32'd1);
        check("sw_d", mw_d, 32'h0);

        // load timeout
        ir_in = {LW, 27'h0}; o_in = 32'h44; xm_valid = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            xm_valid = 1'b0;
            n++;
            if (mw_valid) break;
        end
        check("to_latency", 32'(n), 32'd65);
        check("to_d", mw_d, 32'h0);
        check("to_err", 32'(mem_err), 32'd1);
        repeat (3) @(negedge clk);
        check("to_err_sticky", 32'(mem_err), 32'd1);

        // flush during access
        ir_in = {LW, 27'h0}; o_in = 32'h50; xm_valid = 1'b1;
        @(negedge clk);
        xm_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        check("kill_req_held", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        check("kill_no_valid", 32'(mw_valid), 32'd0);
        check("kill_idle", 32'(xm_ready), 32'd1);
        ir_in = 32'h0; o_in = 32'h77; xm_valid = 1'b1;
        @(negedge clk);
        xm_valid = 1'b0;
        check("kill_next_add", mw_o, 32'h77);
        check("kill_next_valid", 32'(mw_valid), 32'd1);

        // output stall, then flush in idle
        @(negedge clk);
        mw_ready = 1'b0;
        ir_in = 32'h0000_0ABC; o_in = 32'hABC; xm_valid = 1'b1;
        @(negedge clk);
        ir_in = 32'h0800_0001; o_in = 32'h999;
        for (int i = 0; i < 5; i++) begin
            check("stall_xm_ready", 32'(xm_ready), 32'd0);
            check("stall_valid", 32'(mw_valid), 32'd1);
            check("stall_o", mw_o, 32'hABC);
            check("stall_ir", mw_ir, 32'h0000_0ABC);
            @(negedge clk);
        end
        xm_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mw_ready = 1'b1;
        check("flush_idle", 32'(mw_valid), 32'd0);

        // reset mid-access, late ack ignored
        ir_in = {LW, 27'h0}; o_in = 32'h66; xm_valid = 1'b1;
        @(negedge clk);
        xm_valid = 1'b0;
        check("rst_mid_req", 32'(mem_req), 32'd1);
        #2 clear_n = 1'b0;
        #1;
        check("arst_req", 32'(mem_req), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_err", 32'(mem_err), 32'd0);
        check("arst_o", mw_o, 32'd0);
        check("arst_ir", mw_ir, 32'd0);
        @(negedge clk);
        clear_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_valid", 32'(mw_valid), 32'd0);
        check("late_ack_req", 32'(mem_req), 32'd0);

        // random traffic
        do_reset();
        exp_q.delete();
        pend_q.delete();
        for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
        n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 200) begin
            rnd_cycle(1'b0);
            n++;
        end
        check("rnd_drain_exp", 32'(exp_q.size()), 32'd0);
        check("rnd_drain_pend", 32'(pend_q.size()), 32'd0);
        check("rnd_no_err", 32'(mem_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
